pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central hazard and syscall sequencer for the 5-stage MIPS pipeline. Detects load-use hazards between decode and execute, converts taken branches into a fetch/decode flush, and runs syscalls: drain, environment service handshake, resume or halt. Drives the stall/flush/syscall controls of the fetch/decode pipeline register, the PC write enable and the decode/execute bubble insert. Also keeps a saturating stall-cycle counter.

## Interface
- DRAIN_CYCLES, default 3: cycles to wait after a syscall leaves decode so older instructions (EX, MEM, WB) retire; legal range 1..15.
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- idRs_i  in  5  rs field of the instruction in decode.
- idRt_i  in  5  rt field of the instruction in decode.
- idUsesRt_i  in  1  the decode instruction reads rt as a source.
- idSyscall_i  in  1  the decode instruction is SYSCALL.
- exMemRead_i  in  1  the instruction in EX is a load.
- exRt_i  in  5  destination register of the load in EX.
- exBranchTaken_i  in  1  the branch/jump in EX is taken this cycle.
- sysV0_i  in  32  current $v0 value; sampled on the service handshake.
- sysAck_i  in  1  the environment has completed the syscall.
- loadStall_o  out  1  hold the fetch/decode register.
- branchFlush_o  out  1  zero the fetch/decode register.
- syscallFlag_o  out  1  zero the fetch/decode register and freeze the front end.
- idexBubble_o  out  1  load a NOP into decode/execute.
- pcWriteEn_o  out  1  PC may update.
- sysReq_o  out  1  syscall service request.
- halted_o  out  1  exit syscall has completed.
- stallCount_o  out  32  saturating count of stalled cycles.

## Operation
- Outputs are combinational from state and inputs. The exception is stallCount_o, which is a register.
- FSM states: RUN, DRAIN, SERVICE, HALT. Reset state is RUN.
- Load-use hazard: hz = exMemRead_i & (exRt_i != 0) & (exRt_i == idRs_i | (idUsesRt_i & exRt_i == idRt_i)).
- RUN has a fixed priority:
  - exBranchTaken_i first: branchFlush_o=1, idexBubble_o=1, pcWriteEn_o=1, and all other control outputs 0. This holds even if hz or idSyscall_i is also true. The state stays RUN.
  - else idSyscall_i: syscallFlag_o=1, idexBubble_o=1, pcWriteEn_o=0. The drain counter loads DRAIN_CYCLES. The next state is DRAIN.
  - else hz: loadStall_o=1, idexBubble_o=1, pcWriteEn_o=0.
  - else pcWriteEn_o=1 and all other control outputs 0.
- DRAIN:
  - Outputs: syscallFlag_o=1, idexBubble_o=1, pcWriteEn_o=0.
  - The counter decrements each cycle. The cycle in which the counter reads 1 moves the FSM to SERVICE.
  - exBranchTaken_i is ignored, because no branch can be in EX behind a drained syscall.
- SERVICE:
  - Outputs: sysReq_o=1, syscallFlag_o=1, pcWriteEn_o=0, idexBubble_o=1.
  - sysReq_o stays high until the cycle in which sysAck_i=1.
  - On ack with sysV0_i==10, the next state is HALT. On ack with any other value, the next state is RUN.
- HALT: syscallFlag_o=1, halted_o=1, pcWriteEn_o=0, idexBubble_o=1. The FSM leaves HALT only on reset.
- stallCount_o increments by 1 on each clock where pcWriteEn_o==0 in RUN, DRAIN or SERVICE. It saturates at 0xFFFFFFFF and does not count in HALT.
- While rst_n=0, every output is 0, including pcWriteEn_o. stallCount_o resets to 0. The counter and FSM clear immediately.

## Timing
- Hazard, flush and syscall-entry responses are zero-latency (the same cycle as the input).
- Load-use stall lasts exactly 1 cycle: the bubble removes the load from EX next cycle.
- Syscall sequence from detection to sysReq_o: 1 + DRAIN_CYCLES cycles.
- Ack to resume: RUN with pcWriteEn_o=1 on the cycle after sysAck_i. The PC still holds syscall address + 4.
- sysAck_i outside SERVICE is ignored. sysV0_i is only sampled in the ack cycle.
- Reset asserted mid-DRAIN or mid-SERVICE aborts the sequence and drops sysReq_o asynchronously. After release the FSM is in RUN.

## Structure
- Shared pipeline package:
  - FSM state enum (2 bits).
  - SYSCALL_EXIT = 32'd10.
  - Register-zero constant REG_ZERO = 5'd0.
- Single module, no sub-modules. The hazard compare is a local function.

## Test plan
- Load-use: exMemRead_i=1, exRt_i=8, idRs_i=8 → loadStall_o=1, idexBubble_o=1, pcWriteEn_o=0 for 1 cycle; stallCount_o goes 0→1. Same stimulus with exRt_i=0 → no stall.
- Branch versus hazard: exBranchTaken_i=1 and hz=1 in the same cycle → branchFlush_o=1, loadStall_o=0, pcWriteEn_o=1.
- Syscall resume: idSyscall_i=1, DRAIN_CYCLES=3 → syscallFlag_o high 4 cycles, then sysReq_o. sysAck_i after 5 cycles with sysV0_i=4 → RUN next cycle; stallCount_o=10.
- Exit: same sequence with sysV0_i=10 at ack → halted_o=1 and pcWriteEn_o=0 indefinitely; stallCount_o frozen.
- Reset mid-SERVICE: drop rst_n while sysReq_o=1 → all outputs 0 immediately; after release, RUN with stallCount_o=0.
- Saturation: force stallCount_o near 0xFFFFFFFE, then stall 3 cycles → stallCount_o holds at 0xFFFFFFFF.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/syscall sequencer:
// FSM states, architectural constants and the bundled control word.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_SERVICE = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    localparam logic [31:0] SYSCALL_EXIT = 32'd10;
    localparam logic [4:0]  REG_ZERO     = 5'd0;

    // Front-end control word; field order matches the output ports.
    typedef struct packed {
        logic load_stall;
        logic branch_flush;
        logic syscall_flag;
        logic idex_bubble;
        logic pc_write_en;
        logic sys_req;
        logic halted;
    } ctrl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and syscall sequencer: load-use stall, branch flush, syscall
// drain/service/halt, plus a saturating stall-cycle counter.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  idRs_i,
    input  logic [4:0]  idRt_i,
    input  logic        idUsesRt_i,
    input  logic        idSyscall_i,
    input  logic        exMemRead_i,
    input  logic [4:0]  exRt_i,
    input  logic        exBranchTaken_i,
    input  logic [31:0] sysV0_i,
    input  logic        sysAck_i,
    output logic        loadStall_o,
    output logic        branchFlush_o,
    output logic        syscallFlag_o,
    output logic        idexBubble_o,
    output logic        pcWriteEn_o,
    output logic        sysReq_o,
    output logic        halted_o,
    output logic [31:0] stallCount_o
);

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

    state_t      state;
    logic [3:0]  drain_cnt;
    logic [31:0] stall_count;
    ctrl_t       ctrl;
    ctrl_t       ctrl_gated;
    logic        hazard;

    function automatic logic load_use(
        input logic       mem_read,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       uses_rt
    );
        return mem_read && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
    endfunction

    assign hazard = load_use(exMemRead_i, exRt_i, idRs_i, idRt_i, idUsesRt_i);

    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves a latch.
        ctrl = '0;
        unique case (state)
            ST_RUN: begin
                if (exBranchTaken_i) begin
                    ctrl.branch_flush = 1'b1;
                    ctrl.idex_bubble  = 1'b1;
                    ctrl.pc_write_en  = 1'b1;
                end else if (idSyscall_i) begin
                    ctrl.syscall_flag = 1'b1;
                    ctrl.idex_bubble  = 1'b1;
                end else if (hazard) begin
                    ctrl.load_stall   = 1'b1;
                    ctrl.idex_bubble  = 1'b1;
                end else begin
                    ctrl.pc_write_en  = 1'b1;
                end
            end
            ST_DRAIN: begin
                ctrl.syscall_flag = 1'b1;
                ctrl.idex_bubble  = 1'b1;
            end
            ST_SERVICE: begin
                ctrl.syscall_flag = 1'b1;
                ctrl.idex_bubble  = 1'b1;
                ctrl.sys_req      = 1'b1;
            end
            ST_HALT: begin
                ctrl.syscall_flag = 1'b1;
                ctrl.idex_bubble  = 1'b1;
                ctrl.halted       = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    // Gating with rst_n makes the whole control word, including the PC
    // enable and sysReq_o, drop asynchronously the moment reset asserts.
    assign ctrl_gated = rst_n ? ctrl : '0;

    assign loadStall_o   = ctrl_gated.load_stall;
    assign branchFlush_o = ctrl_gated.branch_flush;
    assign syscallFlag_o = ctrl_gated.syscall_flag;
    assign idexBubble_o  = ctrl_gated.idex_bubble;
    assign pcWriteEn_o   = ctrl_gated.pc_write_en;
    assign sysReq_o      = ctrl_gated.sys_req;
    assign halted_o      = ctrl_gated.halted;
    assign stallCount_o  = stall_count;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (!exBranchTaken_i && idSyscall_i) begin
                        drain_cnt <= DRAIN_LOAD;
                        state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    drain_cnt <= drain_cnt - 4'd1;
                    if (drain_cnt == 4'd1) state <= ST_SERVICE;
                end
                ST_SERVICE: begin
                    if (sysAck_i) state <= (sysV0_i == SYSCALL_EXIT) ? ST_HALT : ST_RUN;
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if ((state != ST_HALT) && !ctrl.pc_write_en && (stall_count != '1)) begin
            stall_count <= stall_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: table-driven vectors through
// an expected-value queue, plus reset-abort and counter-saturation sequences.
module tb_pipeline_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic [4:0]  idRs_i, idRt_i, exRt_i;
    logic        idUsesRt_i, idSyscall_i, exMemRead_i, exBranchTaken_i, sysAck_i;
    logic [31:0] sysV0_i;
    logic        loadStall_o, branchFlush_o, syscallFlag_o, idexBubble_o;
    logic        pcWriteEn_o, sysReq_o, halted_o;
    logic [31:0] stallCount_o;

    int errors = 0;
    int checks = 0;

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .idRs_i(idRs_i), .idRt_i(idRt_i), .idUsesRt_i(idUsesRt_i),
        .idSyscall_i(idSyscall_i), .exMemRead_i(exMemRead_i), .exRt_i(exRt_i),
        .exBranchTaken_i(exBranchTaken_i), .sysV0_i(sysV0_i), .sysAck_i(sysAck_i),
        .loadStall_o(loadStall_o), .branchFlush_o(branchFlush_o),
        .syscallFlag_o(syscallFlag_o), .idexBubble_o(idexBubble_o),
        .pcWriteEn_o(pcWriteEn_o), .sysReq_o(sysReq_o), .halted_o(halted_o),
        .stallCount_o(stallCount_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control pattern order: {stall, flush, sysflag, bubble, pcwe, req, halted}
    localparam logic [6:0] P_ZERO = 7'b0000000;
    localparam logic [6:0] P_RUN  = 7'b0000100;
    localparam logic [6:0] P_LOAD = 7'b1001000;
    localparam logic [6:0] P_BR   = 7'b0101100;
    localparam logic [6:0] P_SYS  = 7'b0011000;
    localparam logic [6:0] P_SVC  = 7'b0011010;
    localparam logic [6:0] P_HLT  = 7'b0011001;

    typedef struct {
        logic [4:0]  rs, rt, ex_rt;
        logic        uses_rt, syscall, mem_read, br, ack;
        logic [31:0] v0;
        logic [6:0]  exp_ctrl;
        logic [31:0] exp_count;
    } vec_t;

    typedef struct {
        logic [6:0]  ctrl;
        logic [31:0] count;
    } exp_t;

    vec_t vecs[27];
    exp_t sb[$];

    function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                                input logic uses_rt, input logic syscall,
                                input logic mem_read, input logic [4:0] ex_rt,
                                input logic br, input logic [31:0] v0, input logic ack,
                                input logic [6:0] exp_ctrl, input logic [31:0] exp_count);
        vec_t v;
        v.rs = rs; v.rt = rt; v.uses_rt = uses_rt; v.syscall = syscall;
        v.mem_read = mem_read; v.ex_rt = ex_rt; v.br = br; v.v0 = v0; v.ack = ack;
        v.exp_ctrl = exp_ctrl; v.exp_count = exp_count;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic logic [6:0] ctrl_now();
        return {loadStall_o, branchFlush_o, syscallFlag_o, idexBubble_o,
                pcWriteEn_o, sysReq_o, halted_o};
    endfunction

    task automatic drive(input vec_t v);
        idRs_i = v.rs; idRt_i = v.rt; idUsesRt_i = v.uses_rt; idSyscall_i = v.syscall;
        exMemRead_i = v.mem_read; exRt_i = v.ex_rt; exBranchTaken_i = v.br;
        sysV0_i = v.v0; sysAck_i = v.ack;
    endtask

    task automatic idle();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, P_RUN, 0));
    endtask

    task automatic compare_front(input string tag);
        exp_t e;
        e = sb.pop_front();
        check({tag, " ctrl"}, {25'd0, ctrl_now()}, {25'd0, e.ctrl});
        check({tag, " count"}, stallCount_o, e.count);
    endtask

    initial begin
        exp_t e;
        bit   seen;

        // Main sequence starts from a fresh reset: count 0, state RUN.
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, P_RUN,  0);
        vecs[1]  = mk(8, 0, 0, 0, 1, 8, 0, 0,  0, P_LOAD, 0);   // load-use on rs
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, P_RUN,  1);
        vecs[3]  = mk(0, 0, 0, 0, 1, 0, 0, 0,  0, P_RUN,  1);   // $zero never hazards
        vecs[4]  = mk(3, 9, 1, 0, 1, 9, 0, 0,  0, P_LOAD, 1);   // load-use on rt
        vecs[5]  = mk(3, 9, 0, 0, 1, 9, 0, 0,  0, P_RUN,  2);   // rt not a source
        vecs[6]  = mk(8, 0, 0, 1, 1, 8, 1, 0,  0, P_BR,   2);   // branch beats all
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, P_RUN,  2);
        vecs[8]  = mk(0, 0, 0, 1, 0, 0, 0, 0,  0, P_SYS,  2);   // syscall detected
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 10, 1, P_SYS,  3);   // ack outside SERVICE
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 1, 0,  0, P_SYS,  4);   // branch in DRAIN
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, P_SYS,  5);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 10, 0, P_SVC,  6);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 10, 0, P_SVC,  7);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 10, 0, P_SVC,  8);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 10, 0, P_SVC,  9);
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 10, 0, P_SVC,  10);
        vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 4,  1, P_SVC,  11);  // ack, resume
        vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, P_RUN,  12);  // 10 stalls for the syscall
        vecs[19] = mk(0, 0, 0, 1, 0, 0, 0, 0,  0, P_SYS,  12);  // exit syscall
        vecs[20] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, P_SYS,  13);
        vecs[21] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, P_SYS,  14);
        vecs[22] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, P_SYS,  15);
        vecs[23] = mk(0, 0, 0, 0, 0, 0, 0, 10, 1, P_SVC,  16);  // ack with exit code
        vecs[24] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, P_HLT,  17);
        vecs[25] = mk(8, 0, 0, 0, 1, 8, 1, 0,  0, P_HLT,  17);  // frozen in HALT
        vecs[26] = mk(0, 0, 0, 1, 0, 0, 0, 4,  1, P_HLT,  17);

        rst_n = 1'b0;
        idle();
        #12;
        check("reset ctrl", {25'd0, ctrl_now()}, {25'd0, P_ZERO});
        check("reset count", stallCount_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i]);
            e.ctrl = vecs[i].exp_ctrl;
            e.count = vecs[i].exp_count;
            sb.push_back(e);
            #2;
            compare_front($sformatf("vec%0d", i));
        end

        // Reset mid-SERVICE: outputs drop immediately, RUN with count 0 afterwards.
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        idle();
        idSyscall_i = 1'b1;
        @(negedge clk);
        idle();
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            #1;
            seen = sysReq_o;
        end
        check("sysreq reached", {31'd0, seen}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        e.ctrl = P_ZERO; e.count = 32'd0;
        sb.push_back(e);
        compare_front("abort");
        @(negedge clk);
        rst_n = 1'b1;
        e.ctrl = P_RUN; e.count = 32'd0;
        sb.push_back(e);
        #2;
        compare_front("after abort");

        // Saturation: preload near the top, then hold a load-use stall.
        @(negedge clk);
        drive(mk(8, 0, 0, 0, 1, 8, 0, 0, 0, P_LOAD, 0));
        force dut.stall_count = 32'hFFFF_FFFE;
        #1;
        release dut.stall_count;
        #1;
        e.ctrl = P_LOAD; e.count = 32'hFFFF_FFFE;
        sb.push_back(e);
        compare_front("sat0");
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            e.ctrl = P_LOAD; e.count = 32'hFFFF_FFFF;
            sb.push_back(e);
            #2;
            compare_front($sformatf("sat%0d", k));
        end

        idle();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
